// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider, raster counters, coordinates, sync/blank with delay line.
// Optional VGA_TIMING_FRAME_TICK_EN builds the once-per-frame tick at the start of vertical blank.
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_pix_en,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_blank_n,
  output logic       o_frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] c_DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_HV       = 10'(H_VISIBLE);
  localparam logic [9:0] c_VV       = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      H_TOTAL > 1024 || V_TOTAL > 1024 ||
      CLK_DIV < 1 || CLK_DIV > 8 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DW-1:0] r_div;
  logic [9:0]    r_hcount;
  logic [9:0]    r_vcount;
  logic          r_pix_en;
  logic [9:0]    r_x;
  logic [8:0]    r_y;
  logic          r_hs_n;
  logic          r_vs_n;
  logic          r_bl;

  logic          w_adv;
  logic [9:0]    w_h_next;
  logic [9:0]    w_v_next;
  logic [9:0]    w_x_next;
  logic [8:0]    w_y_next;
  logic          w_hs_n_next;
  logic          w_vs_n_next;
  logic          w_bl_next;

  assign w_adv = (r_div == c_DIV_LAST);

  always_comb begin
    w_h_next = r_hcount;
    w_v_next = r_vcount;
    if (w_adv) begin
      if (r_hcount == c_H_LAST) begin
        w_h_next = 10'd0;
        w_v_next = (r_vcount == c_V_LAST) ? 10'd0 : r_vcount + 10'd1;
      end else begin
        w_h_next = r_hcount + 10'd1;
      end
    end
  end

  // Coordinate and sync terms are decoded from the next counter values so they
  // land in the same register update as the counters themselves.
  assign w_x_next    = (w_h_next < c_HV) ? w_h_next : 10'd0;
  assign w_y_next    = (w_v_next < c_VV) ? w_v_next[8:0] : 9'd0;
  assign w_hs_n_next = !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
  assign w_vs_n_next = !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
  assign w_bl_next   = (w_h_next < c_HV) && (w_v_next < c_VV);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div    <= '0;
      r_hcount <= 10'd0;
      r_vcount <= 10'd0;
      r_pix_en <= 1'b0;
      r_x      <= 10'd0;
      r_y      <= 9'd0;
      r_hs_n   <= 1'b1;
      r_vs_n   <= 1'b1;
      r_bl     <= 1'b0;
    end else begin
      r_div    <= w_adv ? '0 : r_div + 1'b1;
      r_pix_en <= w_adv;
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      if (w_adv) begin
        r_x    <= w_x_next;
        r_y    <= w_y_next;
        r_hs_n <= w_hs_n_next;
        r_vs_n <= w_vs_n_next;
        r_bl   <= w_bl_next;
      end
    end
  end

  assign o_pix_en = r_pix_en;
  assign o_x      = r_x;
  assign o_y      = r_y;

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign o_hsync_n = r_hs_n;
    assign o_vsync_n = r_vs_n;
    assign o_blank_n = r_bl;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] r_hs_d;
    logic [SYNC_DELAY-1:0] r_vs_d;
    logic [SYNC_DELAY-1:0] r_bl_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_hs_d <= '1;
        r_vs_d <= '1;
        r_bl_d <= '0;
      end else begin
        r_hs_d <= (r_hs_d << 1) | SYNC_DELAY'(r_hs_n);
        r_vs_d <= (r_vs_d << 1) | SYNC_DELAY'(r_vs_n);
        r_bl_d <= (r_bl_d << 1) | SYNC_DELAY'(r_bl);
      end
    end

    assign o_hsync_n = r_hs_d[SYNC_DELAY-1];
    assign o_vsync_n = r_vs_d[SYNC_DELAY-1];
    assign o_blank_n = r_bl_d[SYNC_DELAY-1];
  end

`ifdef VGA_TIMING_FRAME_TICK_EN
  localparam logic [9:0] c_H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] c_V_VIS_LAST = 10'(V_VISIBLE - 1);

  logic r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_adv && (r_hcount == c_H_VIS_LAST) && (r_vcount == c_V_VIS_LAST);
    end
  end

  assign o_frame_tick = r_tick;
`else
  assign o_frame_tick = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-raster instances, random async resets, queued expectations.
`default_nettype none

module tb_vga_timing_gen;

  localparam int HV = 20, HF = 3, HS = 4, HB = 5;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int NCYC = 6000;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] x;
    logic [8:0] y;
    logic       hs_n;
    logic       vs_n;
    logic       bl_n;
    logic       tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obs_t act_a, act_b;
  obs_t qa[$];
  obs_t qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(2), .SYNC_DELAY(1)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_en(act_a.pix_en), .o_x(act_a.x), .o_y(act_a.y),
    .o_hsync_n(act_a.hs_n), .o_vsync_n(act_a.vs_n), .o_blank_n(act_a.bl_n), .o_frame_tick(act_a.tick)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(1), .SYNC_DELAY(0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .o_pix_en(act_b.pix_en), .o_x(act_b.x), .o_y(act_b.y),
    .o_hsync_n(act_b.hs_n), .o_vsync_n(act_b.vs_n), .o_blank_n(act_b.bl_n), .o_frame_tick(act_b.tick)
  );

  function automatic obs_t reset_obs();
    obs_t e;
    e = '{pix_en: 1'b0, x: 10'd0, y: 9'd0, hs_n: 1'b1, vs_n: 1'b1, bl_n: 1'b0, tick: 1'b0};
    return e;
  endfunction

  // Expected outputs n clk edges after reset release: pixel index is n/cdiv,
  // raster position follows from it, and sync/blank describe the pixel sdel clks earlier.
  // The pixel shown before the first advance keeps the reset-time blank.
  function automatic obs_t model(int cdiv, int sdel, longint n);
    obs_t   e;
    longint p, m, pp;
    int     h, v, hh, vv;
    e = reset_obs();
    p = n / cdiv;
    h = int'(p % HT);
    v = int'((p / HT) % VT);
    e.pix_en = (n > 0) && (n % cdiv == 0);
    e.x = (h < HV) ? 10'(h) : 10'd0;
    e.y = (v < VV) ? 9'(v) : 9'd0;
    m = n - sdel;
    if (m >= cdiv) begin
      pp = m / cdiv;
      hh = int'(pp % HT);
      vv = int'((pp / HT) % VT);
      e.hs_n = !(hh >= HV + HF && hh < HV + HF + HS);
      e.vs_n = !(vv >= VV + VF && vv < VV + VF + VS);
      e.bl_n = (hh < HV) && (vv < VV);
    end
`ifdef VGA_TIMING_FRAME_TICK_EN
    e.tick = (n > 0) && (n % cdiv == 0) && (p % (HT * VT) == longint'((VV - 1) * HT + HV));
`endif
    return e;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got pix_en=%b x=%0d y=%0d hs_n=%b vs_n=%b bl_n=%b tick=%b, expected pix_en=%b x=%0d y=%0d hs_n=%b vs_n=%b bl_n=%b tick=%b",
               name, $time, act.pix_en, act.x, act.y, act.hs_n, act.vs_n, act.bl_n, act.tick,
               exp.pix_en, exp.x, exp.y, exp.hs_n, exp.vs_n, exp.bl_n, exp.tick);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) check("div2_dly1", act_a, qa.pop_front());
    if (qb.size() > 0) check("div1_dly0", act_b, qb.pop_front());
  end

  initial begin
    longint n = 0;
    bit     active = 1'b1;
    int     hold = 5;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (active) n = 0;
      else        n++;
      #2;
      if (active) begin
        hold--;
        if (hold <= 0) begin
          active = 1'b0;
          rst_n  = 1'b1;
        end
      end else if (cyc == 2500 || $urandom_range(0, 1999) == 0) begin
        // asynchronous drop between edges: outputs must already be at reset before the next negedge
        active = 1'b1;
        rst_n  = 1'b0;
        hold   = int'($urandom_range(1, 5));
      end
      qa.push_back(active ? reset_obs() : model(2, 1, n));
      qb.push_back(active ? reset_obs() : model(1, 0, n));
    end
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d unchecked entries, expected 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
